// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the CPU/AUX single-port RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_AUX  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_AUX = 1'b1
  } owner_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Wide enough for BURST_MAX up to 15.
  localparam int unsigned CNT_W = 4;

  // CPU takes a tie unless round robin is on and it owned the bus last.
  function automatic logic cpu_wins_tie(input logic rr_en, input owner_e last_owner);
    return !rr_en || (last_owner != OWNER_CPU);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of both requester ports and the RAM-side port of ram_arbiter.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WR_W   = 8,
  parameter int unsigned RD_W   = 16
);
  logic              cpu_req;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_adrs;
  logic [WR_W-1:0]   cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [RD_W-1:0]   cpu_rdata;

  logic              aux_req;
  logic              aux_rw;
  logic [ADDR_W-1:0] aux_adrs;
  logic [WR_W-1:0]   aux_wdata;
  logic              aux_gnt;
  logic              aux_rvalid;
  logic [RD_W-1:0]   aux_rdata;

  logic              mem_rw;
  logic [ADDR_W-1:0] mem_adrs;
  logic [WR_W-1:0]   mem_wdata;
  logic [RD_W-1:0]   mem_rdata;

  // Requesters and RAM side.
  modport master (
    output cpu_req, cpu_rw, cpu_adrs, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output aux_req, aux_rw, aux_adrs, aux_wdata,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  mem_rw, mem_adrs, mem_wdata,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_rw, cpu_adrs, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  aux_req, aux_rw, aux_adrs, aux_wdata,
    output aux_gnt, aux_rvalid, aux_rdata,
    output mem_rw, mem_adrs, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/ram_arbiter_burst_cnt.sv
// Beat counter bounding one ownership to BURST_MAX granted beats.
module arb_burst_cnt
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr || clear) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign last = (r_cnt == CNT_W'(BURST_MAX - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between the CPU and an AUX master with bounded bursts.
// Define RAM_ARB_RR_EN for round-robin tie-break; otherwise the CPU wins ties.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned WR_W      = 8,
  parameter int unsigned RD_W      = 16
) (
  input  logic          clk,
  input  logic          clr,
  ram_arbiter_if.slave  bus
);

`ifdef RAM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  arb_state_e        r_state;
  owner_e            r_last_owner;
  logic              r_cpu_rvalid;
  logic              r_aux_rvalid;

  logic              w_cpu_gnt;
  logic              w_aux_gnt;
  logic              w_beat;
  logic              w_last;
  logic              w_cnt_clear;
  logic              w_cpu_wins;
  logic              w_mem_rw;
  logic [ADDR_W-1:0] w_mem_adrs;
  logic [WR_W-1:0]   w_mem_wdata;
  logic [RD_W-1:0]   w_rdata;

  assign w_cpu_gnt   = (r_state == ARB_CPU) && bus.cpu_req;
  assign w_aux_gnt   = (r_state == ARB_AUX) && bus.aux_req;
  assign w_beat      = w_cpu_gnt || w_aux_gnt;
  assign w_cnt_clear = (r_state == ARB_IDLE);
  assign w_cpu_wins  = !bus.aux_req || cpu_wins_tie(RR_EN, r_last_owner);

  arb_burst_cnt #(
    .BURST_MAX (BURST_MAX)
  ) u_burst_cnt (
    .clk   (clk),
    .clr   (clr),
    .clear (w_cnt_clear),
    .inc   (w_beat),
    .last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state      <= ARB_IDLE;
      r_last_owner <= OWNER_AUX;
      r_cpu_rvalid <= 1'b0;
      r_aux_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt && (bus.cpu_rw == RW_READ);
      r_aux_rvalid <= w_aux_gnt && (bus.aux_rw == RW_READ);
      case (r_state)
        ARB_IDLE: begin
          if (bus.cpu_req && w_cpu_wins) begin
            r_state      <= ARB_CPU;
            r_last_owner <= OWNER_CPU;
          end else if (bus.aux_req) begin
            r_state      <= ARB_AUX;
            r_last_owner <= OWNER_AUX;
          end
        end
        // A dropped request or the final beat of a burst both hand back via IDLE.
        ARB_CPU: if (!bus.cpu_req || w_last) r_state <= ARB_IDLE;
        ARB_AUX: if (!bus.aux_req || w_last) r_state <= ARB_IDLE;
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    w_mem_rw    = RW_READ;
    w_mem_adrs  = '0;
    w_mem_wdata = '0;
    if (w_cpu_gnt) begin
      w_mem_rw    = bus.cpu_rw;
      w_mem_adrs  = bus.cpu_adrs;
      w_mem_wdata = bus.cpu_wdata;
    end else if (w_aux_gnt) begin
      w_mem_rw    = bus.aux_rw;
      w_mem_adrs  = bus.aux_adrs;
      w_mem_wdata = bus.aux_wdata;
    end
  end

  assign w_rdata        = bus.mem_rdata;
  assign bus.mem_rw     = w_mem_rw;
  assign bus.mem_adrs   = w_mem_adrs;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.aux_gnt    = w_aux_gnt;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.aux_rvalid = r_aux_rvalid;
  assign bus.cpu_rdata  = w_rdata;
  assign bus.aux_rdata  = w_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: queue-fed requesters, a one-cycle RAM model and an rdata scoreboard.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  typedef struct packed {
    logic        rw;
    logic [7:0]  adrs;
    logic [7:0]  wdata;
    logic [15:0] exp;
  } cmd_t;

  logic clk = 1'b0;
  logic clr;

  ram_arbiter_if #(.ADDR_W(8), .WR_W(8), .RD_W(16)) bus ();

  ram_arbiter #(
    .BURST_MAX (4),
    .ADDR_W    (8),
    .WR_W      (8),
    .RD_W      (16)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  cmd_t        cpu_q[$];
  cmd_t        aux_q[$];
  logic [15:0] cpu_exp[$];
  logic [15:0] aux_exp[$];
  logic [3:0]  trace[$];
  logic        rec = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_fail = 0;

  // RAM model: contents B000+addr, writes store zero-extended din, dout one cycle later.
  logic        ram_ready = 1'b0;
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'hB000 + 16'(i);
      ram_ready <= 1'b1;
    end else if (bus.mem_rw == RW_WRITE) begin
      ram[bus.mem_adrs] <= {8'h00, bus.mem_wdata};
    end
    bus.mem_rdata <= ram[bus.mem_adrs];
  end

  function automatic cmd_t mk(input logic rw, input logic [7:0] a, input logic [7:0] d,
                              input logic [15:0] e);
    cmd_t c;
    c.rw = rw; c.adrs = a; c.wdata = d; c.exp = e;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  // Trace bits: 3 cpu_gnt, 2 cpu_rvalid, 1 aux_gnt, 0 aux_rvalid.
  function automatic string trace_str(input int unsigned b);
    string s = "";
    foreach (trace[k]) s = {s, trace[k][b] ? "1" : "0"};
    return s;
  endfunction

  task automatic start_trace();
    trace.delete();
    rec = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int unsigned k = 0;
    while ((cpu_q.size() + aux_q.size() + cpu_exp.size() + aux_exp.size()) != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    check(name, 32'(k < 300), 32'd1);
    repeat (4) @(posedge clk);
  endtask

  // CPU requester: holds the head command until granted, then moves on.
  initial begin
    cmd_t c;
    logic g, r;
    bus.cpu_req = 1'b0; bus.cpu_rw = RW_READ; bus.cpu_adrs = '0; bus.cpu_wdata = '0;
    forever begin
      @(negedge clk); g = bus.cpu_gnt; r = clr;
      @(posedge clk);
      if (g && cpu_q.size() > 0) begin
        c = cpu_q.pop_front();
        if (c.rw == RW_READ && !r) cpu_exp.push_back(c.exp);
      end
      #1;
      if (cpu_q.size() > 0) begin
        c = cpu_q[0];
        bus.cpu_req = 1'b1; bus.cpu_rw = c.rw; bus.cpu_adrs = c.adrs; bus.cpu_wdata = c.wdata;
      end else begin
        bus.cpu_req = 1'b0; bus.cpu_rw = RW_READ; bus.cpu_adrs = '0; bus.cpu_wdata = '0;
      end
    end
  end

  initial begin
    cmd_t c;
    logic g, r;
    bus.aux_req = 1'b0; bus.aux_rw = RW_READ; bus.aux_adrs = '0; bus.aux_wdata = '0;
    forever begin
      @(negedge clk); g = bus.aux_gnt; r = clr;
      @(posedge clk);
      if (g && aux_q.size() > 0) begin
        c = aux_q.pop_front();
        if (c.rw == RW_READ && !r) aux_exp.push_back(c.exp);
      end
      #1;
      if (aux_q.size() > 0) begin
        c = aux_q[0];
        bus.aux_req = 1'b1; bus.aux_rw = c.rw; bus.aux_adrs = c.adrs; bus.aux_wdata = c.wdata;
      end else begin
        bus.aux_req = 1'b0; bus.aux_rw = RW_READ; bus.aux_adrs = '0; bus.aux_wdata = '0;
      end
    end
  end

  // Monitor: scoreboard on rvalid, mux and exclusivity checks every cycle.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rec) trace.push_back({bus.cpu_gnt, bus.cpu_rvalid, bus.aux_gnt, bus.aux_rvalid});
      if (bus.cpu_rvalid) begin
        if (cpu_exp.size() == 0) check("cpu_unexpected_rvalid", 32'd1, 32'd0);
        else begin e = cpu_exp.pop_front(); check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e)); end
      end
      if (bus.aux_rvalid) begin
        if (aux_exp.size() == 0) check("aux_unexpected_rvalid", 32'd1, 32'd0);
        else begin e = aux_exp.pop_front(); check("aux_rdata", 32'(bus.aux_rdata), 32'(e)); end
      end
      check("gnt_exclusive", 32'(bus.cpu_gnt & bus.aux_gnt), 32'd0);
      if (bus.cpu_gnt)
        check("mux_cpu", 32'({bus.mem_rw, bus.mem_adrs, bus.mem_wdata}),
              32'({bus.cpu_rw, bus.cpu_adrs, bus.cpu_wdata}));
      else if (bus.aux_gnt)
        check("mux_aux", 32'({bus.mem_rw, bus.mem_adrs, bus.mem_wdata}),
              32'({bus.aux_rw, bus.aux_adrs, bus.aux_wdata}));
      else
        check("mux_idle", 32'({bus.mem_rw, bus.mem_adrs, bus.mem_wdata}), 32'h10000);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with an AUX write pending: nothing may be granted or written.
    clr = 1'b1;
    aux_q.push_back(mk(RW_WRITE, 8'h30, 8'hEE, 16'h0000));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
    check("rst_aux_gnt",    32'(bus.aux_gnt),    32'd0);
    check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("rst_aux_rvalid", 32'(bus.aux_rvalid), 32'd0);
    check("rst_mem_rw",     32'(bus.mem_rw),     32'd1);
    check("rst_mem_adrs",   32'(bus.mem_adrs),   32'd0);
    check("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    check("rst_ram_30",     32'(ram[8'h30]),     32'h0000_B030);
    @(posedge clk); #1 clr = 1'b0;
    wait_drain("drain_rst_write");

    // CPU-only read: gnt at N+1, rvalid at N+2.
    @(negedge clk);
    cpu_q.push_back(mk(RW_READ, 8'h10, 8'h00, 16'hB010));
    @(posedge clk); start_trace();
    repeat (4) @(posedge clk); rec = 1'b0;
    check_str("single_cpu_gnt",    trace_str(3), "0100");
    check_str("single_cpu_rvalid", trace_str(2), "0010");
    check_str("single_aux_gnt",    trace_str(1), "0000");
    wait_drain("drain_single");

    // Ten CPU reads against BURST_MAX=4: 4, gap, 4, gap, 2.
    @(negedge clk);
    for (int unsigned i = 0; i < 10; i++)
      cpu_q.push_back(mk(RW_READ, 8'h40 + 8'(i), 8'h00, 16'hB040 + 16'(i)));
    @(posedge clk); start_trace();
    repeat (15) @(posedge clk); rec = 1'b0;
    check_str("burst_cpu_gnt",    trace_str(3), "011110111101100");
    check_str("burst_cpu_rvalid", trace_str(2), "001111011110110");
    wait_drain("drain_burst");

    // AUX write, CPU read-back of it and of the write done during reset.
    @(negedge clk);
    aux_q.push_back(mk(RW_WRITE, 8'h20, 8'hA5, 16'h0000));
    wait_drain("drain_aux_write");
    @(negedge clk);
    cpu_q.push_back(mk(RW_READ, 8'h20, 8'h00, 16'h00A5));
    cpu_q.push_back(mk(RW_READ, 8'h30, 8'h00, 16'h00EE));
    wait_drain("drain_cpu_readback");
    @(negedge clk);
    aux_q.push_back(mk(RW_READ, 8'h20, 8'h00, 16'h00A5));
    wait_drain("drain_aux_read");

    // Tie with AUX as last owner: CPU 8 reads, AUX 4 reads.
    @(negedge clk);
    for (int unsigned i = 0; i < 8; i++)
      cpu_q.push_back(mk(RW_READ, 8'h50 + 8'(i), 8'h00, 16'hB050 + 16'(i)));
    for (int unsigned i = 0; i < 4; i++)
      aux_q.push_back(mk(RW_READ, 8'h60 + 8'(i), 8'h00, 16'hB060 + 16'(i)));
    @(posedge clk); start_trace();
    repeat (17) @(posedge clk); rec = 1'b0;
`ifdef RAM_ARB_RR_EN
    check_str("tie_cpu_gnt", trace_str(3), "01111000000111100");
    check_str("tie_aux_gnt", trace_str(1), "00000011110000000");
`else
    check_str("tie_cpu_gnt", trace_str(3), "01111011110000000");
    check_str("tie_aux_gnt", trace_str(1), "00000000000111100");
`endif
    wait_drain("drain_tie");

    // Reset on beat 2 of an AUX burst, then a CPU/AUX tie right after.
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++)
      aux_q.push_back(mk(RW_READ, 8'h70 + 8'(i), 8'h00, 16'hB070 + 16'(i)));
    @(posedge clk); start_trace();
    @(posedge clk);
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk);
    cpu_q.push_back(mk(RW_READ, 8'h11, 8'h00, 16'hB011));
    @(posedge clk); #1 clr = 1'b0;
    repeat (8) @(posedge clk); rec = 1'b0;
    check_str("midrst_aux_gnt",    trace_str(1), "01100001100");
    check_str("midrst_aux_rvalid", trace_str(0), "00100000110");
    check_str("midrst_cpu_gnt",    trace_str(3), "00001000000");
    check_str("midrst_cpu_rvalid", trace_str(2), "00000100000");
    wait_drain("drain_midrst");

    check("cpu_exp_left", 32'(cpu_exp.size()), 32'd0);
    check("aux_exp_left", 32'(aux_exp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
